// File: rtl/l2_perf_pkg.sv
// Shared types and elaboration helpers for the rolling-window performance sampler.
// The record channel field is sized for the largest supported channel count.
package l2_perf_pkg;

    localparam int CH_W_MAX = 8;

    typedef struct packed {
        logic [CH_W_MAX-1:0] ch;
        logic [63:0]         y;
        logic [63:0]         x;
        logic [63:0]         stamp;
    } perf_rec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PUSH = 1'b1
    } push_state_e;

    // Legal parameter set: the window must outlast a full push sweep so a new
    // close can never land while the previous window is still being pushed.
    function automatic bit params_ok(input int num_ch, input int window,
                                     input int depth, input int acc_w);
        return (num_ch >= 1) && (num_ch <= (1 << CH_W_MAX))
            && (window >= num_ch + 1)
            && (depth >= 2) && ((depth & (depth - 1)) == 0)
            && (acc_w >= 1) && (acc_w <= 64);
    endfunction

endpackage

// File: rtl/l2_perf_record_fifo.sv
// First-word-fall-through record FIFO; a push into a full FIFO is accepted when
// the head is popped in the same cycle.
module l2_perf_record_fifo
    import l2_perf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  perf_rec_t push_rec,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output perf_rec_t head_rec
);

    localparam int PTR_W = $clog2(DEPTH);

    perf_rec_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    // NOTE: every signal written here gets a value before any branch, so no latch can form.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (PTR_W + 1)'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        head_rec = empty ? '0 : mem_q[rd_ptr_q];
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers define validity and the head is masked when empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_rec;
        end
    end

endmodule

// File: rtl/l2_rolling_perf_sampler.sv
// Multi-channel rolling-window sampler: accumulates per-channel numerator and
// denominator events per window and streams one timestamped record per channel.
module l2_rolling_perf_sampler
    import l2_perf_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int WINDOW     = 1000,
    parameter  int DEPTH      = 8,
    parameter  int ACC_W      = 32,
    parameter  int SKIP_EMPTY = 0,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [NUM_CH-1:0] num_inc,
    input  logic [NUM_CH-1:0] den_inc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [63:0]       out_yAxisPt,
    output logic [63:0]       out_xAxisPt,
    output logic [63:0]       out_stamp,
    output logic [31:0]       drop_cnt
);

    localparam int               WIN_W   = $clog2(WINDOW);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    if (!params_ok(NUM_CH, WINDOW, DEPTH, ACC_W)) begin : g_param_check
        $error("l2_rolling_perf_sampler: illegal NUM_CH/WINDOW/DEPTH/ACC_W combination");
    end

    logic [63:0]      stamp_q, stamp_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [ACC_W-1:0] acc_y_q [NUM_CH];
    logic [ACC_W-1:0] acc_y_d [NUM_CH];
    logic [ACC_W-1:0] acc_x_q [NUM_CH];
    logic [ACC_W-1:0] acc_x_d [NUM_CH];
    logic [ACC_W-1:0] acc_y_inc [NUM_CH];
    logic [ACC_W-1:0] acc_x_inc [NUM_CH];
    logic [ACC_W-1:0] sh_y_q [NUM_CH];
    logic [ACC_W-1:0] sh_y_d [NUM_CH];
    logic [ACC_W-1:0] sh_x_q [NUM_CH];
    logic [ACC_W-1:0] sh_x_d [NUM_CH];
    logic [63:0]      sh_stamp_q, sh_stamp_d;
    push_state_e      state_q, state_d;
    logic [CH_W-1:0]  idx_q, idx_d;
    logic [31:0]      drop_cnt_q, drop_cnt_d;
    logic             close;
    logic             push_req;
    perf_rec_t        push_rec;
    perf_rec_t        head_rec;
    logic             fifo_full, fifo_empty;
    logic             pop;

    always_comb begin
        close     = en && (win_cnt_q == WIN_W'(WINDOW - 1));
        stamp_d   = stamp_q + 64'd1;
        win_cnt_d = win_cnt_q;
        if (en) begin
            win_cnt_d = close ? '0 : win_cnt_q + WIN_W'(1);
        end
    end

    // The closing cycle's own increments land in the snapshot, not the next window.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            acc_y_inc[i] = acc_y_q[i];
            acc_x_inc[i] = acc_x_q[i];
            if (en && num_inc[i] && (acc_y_q[i] != ACC_MAX)) begin
                acc_y_inc[i] = acc_y_q[i] + ACC_W'(1);
            end
            if (en && den_inc[i] && (acc_x_q[i] != ACC_MAX)) begin
                acc_x_inc[i] = acc_x_q[i] + ACC_W'(1);
            end
            acc_y_d[i] = close ? '0 : acc_y_inc[i];
            acc_x_d[i] = close ? '0 : acc_x_inc[i];
            sh_y_d[i]  = close ? acc_y_inc[i] : sh_y_q[i];
            sh_x_d[i]  = close ? acc_x_inc[i] : sh_x_q[i];
        end
        sh_stamp_d = close ? stamp_q : sh_stamp_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stamp_q    <= '0;
            win_cnt_q  <= '0;
            sh_stamp_q <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_y_q[i] <= '0;
                acc_x_q[i] <= '0;
                sh_y_q[i]  <= '0;
                sh_x_q[i]  <= '0;
            end
        end else begin
            stamp_q    <= stamp_d;
            win_cnt_q  <= win_cnt_d;
            sh_stamp_q <= sh_stamp_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_y_q[i] <= acc_y_d[i];
                acc_x_q[i] <= acc_x_d[i];
                sh_y_q[i]  <= sh_y_d[i];
                sh_x_q[i]  <= sh_x_d[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (close) begin
                    state_d = ST_PUSH;
                    idx_d   = '0;
                end
            end
            ST_PUSH: begin
                if (idx_q == CH_W'(NUM_CH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Push sweep walks the shadow bank; all-zero records are suppressed when enabled.
    always_comb begin
        push_req = 1'b0;
        push_rec = '0;
        if (state_q == ST_PUSH) begin
            push_rec.ch    = CH_W_MAX'(idx_q);
            push_rec.y     = 64'(sh_y_q[idx_q]);
            push_rec.x     = 64'(sh_x_q[idx_q]);
            push_rec.stamp = sh_stamp_q;
            push_req       = !((SKIP_EMPTY != 0) && (sh_y_q[idx_q] == '0)
                                                 && (sh_x_q[idx_q] == '0));
        end
    end

    always_comb begin
        pop        = !fifo_empty && out_ready;
        drop_cnt_d = drop_cnt_q;
        if (push_req && fifo_full && !pop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    l2_perf_record_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push_req),
        .push_rec (push_rec),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_rec (head_rec)
    );

    assign out_valid   = !fifo_empty;
    assign out_ch      = CH_W'(head_rec.ch);
    assign out_yAxisPt = head_rec.y;
    assign out_xAxisPt = head_rec.x;
    assign out_stamp   = head_rec.stamp;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_l2_rolling_perf_sampler.sv
// Self-checking bench: three sampler configurations share one stimulus stream and
// are compared every cycle against a window/record-schedule model of the sampler.
module tb_l2_rolling_perf_sampler;

    localparam int NCH = 2;
    localparam int DEP = 4;
    localparam int NI  = 3;
    localparam int P_WIN  [NI] = '{8, 8, 32};
    localparam int P_ACCW [NI] = '{32, 4, 4};
    localparam int P_SKIP [NI] = '{0, 1, 0};

    typedef struct packed {
        logic [7:0]  ch;
        logic [63:0] y;
        logic [63:0] x;
        logic [63:0] stamp;
    } rec_t;

    logic           clock;
    logic           reset;
    logic           en;
    logic [NCH-1:0] num_inc;
    logic [NCH-1:0] den_inc;
    logic           out_ready;

    logic        o_valid [NI];
    logic [0:0]  o_ch    [NI];
    logic [63:0] o_y     [NI];
    logic [63:0] o_x     [NI];
    logic [63:0] o_st    [NI];
    logic [31:0] o_drop  [NI];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    l2_rolling_perf_sampler #(.NUM_CH(NCH), .WINDOW(8), .DEPTH(DEP), .ACC_W(32), .SKIP_EMPTY(0)) u_a (
        .clock(clock), .reset(reset), .en(en), .num_inc(num_inc), .den_inc(den_inc),
        .out_valid(o_valid[0]), .out_ready(out_ready), .out_ch(o_ch[0]),
        .out_yAxisPt(o_y[0]), .out_xAxisPt(o_x[0]), .out_stamp(o_st[0]), .drop_cnt(o_drop[0]));

    l2_rolling_perf_sampler #(.NUM_CH(NCH), .WINDOW(8), .DEPTH(DEP), .ACC_W(4), .SKIP_EMPTY(1)) u_b (
        .clock(clock), .reset(reset), .en(en), .num_inc(num_inc), .den_inc(den_inc),
        .out_valid(o_valid[1]), .out_ready(out_ready), .out_ch(o_ch[1]),
        .out_yAxisPt(o_y[1]), .out_xAxisPt(o_x[1]), .out_stamp(o_st[1]), .drop_cnt(o_drop[1]));

    l2_rolling_perf_sampler #(.NUM_CH(NCH), .WINDOW(32), .DEPTH(DEP), .ACC_W(4), .SKIP_EMPTY(0)) u_c (
        .clock(clock), .reset(reset), .en(en), .num_inc(num_inc), .den_inc(den_inc),
        .out_valid(o_valid[2]), .out_ready(out_ready), .out_ch(o_ch[2]),
        .out_yAxisPt(o_y[2]), .out_xAxisPt(o_x[2]), .out_stamp(o_st[2]), .drop_cnt(o_drop[2]));

    always #5 clock = ~clock;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: windows counted in enabled cycles; each close schedules one
    // record per channel at a due cycle, and a bounded queue stands in for the buffer.
    longint unsigned m_cyc;
    int              m_win  [NI];
    longint unsigned m_ay   [NI][NCH];
    longint unsigned m_ax   [NI][NCH];
    rec_t            m_fifo [NI][DEP];
    int              m_cnt  [NI];
    longint unsigned m_drop [NI];
    bit              pend_v   [NI][NCH];
    longint unsigned pend_due [NI][NCH];
    rec_t            pend_rec [NI][NCH];

    task automatic model_reset();
        m_cyc = 0;
        for (int k = 0; k < NI; k++) begin
            m_win[k]  = 0;
            m_cnt[k]  = 0;
            m_drop[k] = 0;
            for (int i = 0; i < NCH; i++) begin
                m_ay[k][i]   = 0;
                m_ax[k][i]   = 0;
                pend_v[k][i] = 0;
            end
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            longint unsigned amax = (64'd1 << P_ACCW[k]) - 64'd1;
            if (m_cnt[k] > 0 && out_ready) begin
                for (int j = 0; j < DEP - 1; j++) m_fifo[k][j] = m_fifo[k][j+1];
                m_cnt[k]--;
            end
            for (int i = 0; i < NCH; i++) begin
                if (pend_v[k][i] && pend_due[k][i] == m_cyc) begin
                    pend_v[k][i] = 0;
                    if (!(P_SKIP[k] != 0 && pend_rec[k][i].y == 0 && pend_rec[k][i].x == 0)) begin
                        if (m_cnt[k] < DEP) begin
                            m_fifo[k][m_cnt[k]] = pend_rec[k][i];
                            m_cnt[k]++;
                        end else if (m_drop[k] < 64'hFFFF_FFFF) begin
                            m_drop[k]++;
                        end
                    end
                end
            end
            if (en) begin
                for (int i = 0; i < NCH; i++) begin
                    if (num_inc[i] && m_ay[k][i] < amax) m_ay[k][i]++;
                    if (den_inc[i] && m_ax[k][i] < amax) m_ax[k][i]++;
                end
                if (m_win[k] == P_WIN[k] - 1) begin
                    m_win[k] = 0;
                    for (int i = 0; i < NCH; i++) begin
                        pend_v[k][i]         = 1;
                        pend_due[k][i]       = m_cyc + 1 + longint'(i);
                        pend_rec[k][i].ch    = 8'(i);
                        pend_rec[k][i].y     = m_ay[k][i];
                        pend_rec[k][i].x     = m_ax[k][i];
                        pend_rec[k][i].stamp = m_cyc;
                        m_ay[k][i]           = 0;
                        m_ax[k][i]           = 0;
                    end
                end else begin
                    m_win[k]++;
                end
            end
        end
        m_cyc++;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clock) begin
        if (chk_en && !reset) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("inst%0d out_valid @%0d", k, m_cyc), o_valid[k], m_cnt[k] > 0);
                check($sformatf("inst%0d drop_cnt @%0d", k, m_cyc), o_drop[k], m_drop[k]);
                if (m_cnt[k] > 0) begin
                    check($sformatf("inst%0d out_ch @%0d", k, m_cyc), o_ch[k], m_fifo[k][0].ch);
                    check($sformatf("inst%0d out_y @%0d", k, m_cyc), o_y[k], m_fifo[k][0].y);
                    check($sformatf("inst%0d out_x @%0d", k, m_cyc), o_x[k], m_fifo[k][0].x);
                    check($sformatf("inst%0d out_stamp @%0d", k, m_cyc), o_st[k], m_fifo[k][0].stamp);
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clock);
        reset = 1; en = 0; num_inc = '0; den_inc = '0; out_ready = 0;
        @(negedge clock);
        reset = 0;
    endtask

    task automatic check_rec(input string name, input int k, input longint unsigned ch,
                             input longint unsigned y, input longint unsigned x,
                             input longint unsigned st);
        check({name, " valid"}, o_valid[k], 1);
        check({name, " ch"}, o_ch[k], ch);
        check({name, " y"}, o_y[k], y);
        check({name, " x"}, o_x[k], x);
        check({name, " stamp"}, o_st[k], st);
    endtask

    initial begin
        clock = 0; reset = 0; en = 0; num_inc = '0; den_inc = '0; out_ready = 0;
        #2;

        // Reset held with random inputs: everything reads zero.
        reset = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            en = 1'($urandom); num_inc = 2'($urandom); den_inc = 2'($urandom);
            out_ready = 1'($urandom);
            for (int k = 0; k < NI; k++) begin
                check("reset out_valid", o_valid[k], 0);
                check("reset drop_cnt", o_drop[k], 0);
                check("reset out_ch", o_ch[k], 0);
                check("reset out_y", o_y[k], 0);
                check("reset out_x", o_x[k], 0);
                check("reset out_stamp", o_st[k], 0);
            end
        end
        chk_en = 1;

        // Basic window.
        reset_dut();
        out_ready = 1;
        for (int c = 0; c < 12; c++) begin
            en = 1; num_inc = {1'b0, c < 3}; den_inc = {1'b0, c < 5};
            if (c == 8)  check("basic not yet valid", o_valid[0], 0);
            if (c == 9)  check_rec("basic ch0", 0, 0, 3, 5, 7);
            if (c == 10) check_rec("basic ch1", 0, 1, 0, 0, 7);
            @(negedge clock);
        end

        // Back-pressure and drops over three windows, then drain.
        reset_dut();
        for (int c = 0; c < 26; c++) begin
            en = 1; num_inc = 2'($urandom); den_inc = 2'($urandom); out_ready = 0;
            @(negedge clock);
        end
        check("bp drop_cnt", o_drop[0], 2);
        for (int c = 26; c <= 30; c++) begin
            en = 1; num_inc = 2'($urandom); den_inc = 2'($urandom); out_ready = 1;
            if (c < 30) begin
                check("bp drain valid", o_valid[0], 1);
                check("bp drain ch", o_ch[0], longint'((c - 26) % 2));
                check("bp drain stamp", o_st[0], (c < 28) ? 7 : 15);
            end else begin
                check("bp drained", o_valid[0], 0);
            end
            @(negedge clock);
        end

        // Empty-record suppression on instance 1.
        reset_dut();
        out_ready = 1;
        for (int c = 0; c < 12; c++) begin
            en = 1; num_inc = {c == 2, 1'b0}; den_inc = {c < 4, 1'b0};
            if (c == 9)  check("skip ch0 suppressed", o_valid[1], 0);
            if (c == 10) check_rec("skip ch1", 1, 1, 1, 4, 7);
            if (c == 11) begin
                check("skip single record", o_valid[1], 0);
                check("skip no drops", o_drop[1], 0);
            end
            @(negedge clock);
        end

        // Saturation at ACC_W=4 over a 32-cycle window on instance 2.
        reset_dut();
        out_ready = 1;
        for (int c = 0; c < 35; c++) begin
            en = 1; num_inc = {1'b0, c < 20}; den_inc = '0;
            if (c == 33) check_rec("sat ch0", 2, 0, 15, 0, 31);
            @(negedge clock);
        end

        // Enable gap delays the close by three cycles.
        reset_dut();
        out_ready = 1;
        for (int c = 0; c < 14; c++) begin
            en = !(c >= 3 && c <= 5); num_inc = 2'b01; den_inc = '0;
            if (c == 11) check("en gap not yet valid", o_valid[0], 0);
            if (c == 12) check_rec("en gap ch0", 0, 0, 8, 0, 10);
            @(negedge clock);
        end

        // Reset asserted two cycles after a close, while records are buffered.
        reset_dut();
        for (int c = 0; c <= 9; c++) begin
            en = 1; num_inc = 2'($urandom); den_inc = 2'($urandom); out_ready = 0;
            if (c == 9) begin
                check("midrst valid before", o_valid[0], 1);
                reset = 1;
            end
            @(negedge clock);
        end
        check("midrst valid after", o_valid[0], 0);
        check("midrst drop after", o_drop[0], 0);
        reset = 0;
        for (int c = 0; c < 12; c++) begin
            en = 1; num_inc = {1'b0, c < 2}; den_inc = {1'b0, c < 3}; out_ready = 1;
            if (c < 9)   check("midrst fifo empty", o_valid[0], 0);
            if (c == 9)  check_rec("midrst ch0", 0, 0, 2, 3, 7);
            if (c == 10) check_rec("midrst ch1", 0, 1, 0, 0, 7);
            @(negedge clock);
        end

        // Randomized traffic with alternating congestion and one asynchronous reset.
        reset_dut();
        for (int c = 0; c < 1500; c++) begin
            reset     = (c == 700);
            en        = ($urandom_range(0, 9) != 0);
            num_inc   = 2'($urandom);
            den_inc   = 2'($urandom);
            out_ready = ((c % 200) < 100) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 3) != 0);
            @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
